// File: rtl/pipe_id_ctrl_pkg.sv
// Shared encodings for the ID-stage control: opcodes, functs, ALU ops,
// next-PC and forwarding selects, and the EX control flag bundle.
package pipe_id_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;

  // Don't-care aluc bits are driven as 0.
  localparam logic [3:0] ALUC_ADD = 4'b0000;
  localparam logic [3:0] ALUC_SUB = 4'b0100;
  localparam logic [3:0] ALUC_AND = 4'b0001;
  localparam logic [3:0] ALUC_OR  = 4'b0101;
  localparam logic [3:0] ALUC_XOR = 4'b0010;
  localparam logic [3:0] ALUC_LUI = 4'b0110;
  localparam logic [3:0] ALUC_SLL = 4'b0011;
  localparam logic [3:0] ALUC_SRL = 4'b0111;
  localparam logic [3:0] ALUC_SRA = 4'b1111;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JR  = 2'b10;
  localparam logic [1:0] PC_JMP = 2'b11;

  localparam logic [1:0] FWD_RF     = 2'b00;
  localparam logic [1:0] FWD_EXALU  = 2'b01;
  localparam logic [1:0] FWD_MEMALU = 2'b10;
  localparam logic [1:0] FWD_MEMLD  = 2'b11;

  typedef struct packed {
    logic wreg;
    logic m2reg;
    logic wmem;
    logic aluimm;
    logic shift;
    logic jal;
  } ctl_t;

endpackage

// File: rtl/pipe_id_ctrl_fwd.sv
// Operand forwarding selects and load-use hazard detection for the ID stage.
module pipe_fwd_unit
  import pipe_id_ctrl_pkg::*;
#(
  parameter int RN_W = 5
) (
  input  logic [RN_W-1:0] rs,
  input  logic [RN_W-1:0] rt,
  input  logic            uses_rs,
  input  logic            uses_rt,
  input  logic            ewreg,
  input  logic            em2reg,
  input  logic [RN_W-1:0] ern,
  input  logic            mwreg,
  input  logic            mm2reg,
  input  logic [RN_W-1:0] mrn,
  output logic [1:0]      fwda,
  output logic [1:0]      fwdb,
  output logic            stall
);

  logic e_alu, e_ld, m_wr;

  // r0 is never a real producer, so a zero destination never matches.
  assign e_alu = ewreg & ~em2reg & (ern != '0);
  assign e_ld  = ewreg &  em2reg & (ern != '0);
  assign m_wr  = mwreg & (mrn != '0);

  always_comb begin
    fwda = FWD_RF;
    if (e_alu && ern == rs)     fwda = FWD_EXALU;
    else if (m_wr && mrn == rs) fwda = mm2reg ? FWD_MEMLD : FWD_MEMALU;
    fwdb = FWD_RF;
    if (e_alu && ern == rt)     fwdb = FWD_EXALU;
    else if (m_wr && mrn == rt) fwdb = mm2reg ? FWD_MEMLD : FWD_MEMALU;
  end

  assign stall = e_ld & ((uses_rs & (ern == rs)) | (uses_rt & (ern == rt)));

endmodule

// File: rtl/pipe_id_ctrl.sv
// ID-stage control: instruction decode, next-PC select, hazard handling and
// the ID/EX control register feeding the EX stage.
module pipe_id_ctrl
  import pipe_id_ctrl_pkg::*;
#(
  parameter int RN_W   = 5,
  parameter int ALUC_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       inst,
  input  logic              rsrtequ,
  input  logic              mwreg,
  input  logic              mm2reg,
  input  logic [RN_W-1:0]   mrn,
  output logic              stall,
  output logic [1:0]        pcsource,
  output logic [1:0]        fwda,
  output logic [1:0]        fwdb,
  output logic              regrt,
  output logic              sext,
  output logic              ewreg,
  output logic              em2reg,
  output logic              ewmem,
  output logic              ealuimm,
  output logic              eshift,
  output logic              ejal,
  output logic [ALUC_W-1:0] ealuc,
  output logic [RN_W-1:0]   ern
);

  logic [5:0]        op, fn;
  logic [RN_W-1:0]   rs, rt, rd, rn;
  logic [ALUC_W-1:0] aluc;
  ctl_t              ctl, e_ctl;
  logic              uses_rs, uses_rt, is_beq, is_bne, is_jr, is_j;
  logic              unused_shamt;

  assign op = inst[31:26];
  assign fn = inst[5:0];
  assign rs = inst[25:21];
  assign rt = inst[20:16];
  assign rd = inst[15:11];
  assign unused_shamt = ^inst[10:6];

  always_comb begin
    ctl = '0; aluc = ALUC_ADD; regrt = 1'b0; sext = 1'b0;
    uses_rs = 1'b0; uses_rt = 1'b0;
    is_beq = 1'b0; is_bne = 1'b0; is_jr = 1'b0; is_j = 1'b0;
    case (op)
      OP_RTYPE: begin
        uses_rs = 1'b1; uses_rt = 1'b1; ctl.wreg = 1'b1;
        case (fn)
          FN_ADD: aluc = ALUC_ADD;
          FN_SUB: aluc = ALUC_SUB;
          FN_AND: aluc = ALUC_AND;
          FN_OR:  aluc = ALUC_OR;
          FN_XOR: aluc = ALUC_XOR;
          FN_SLL: begin aluc = ALUC_SLL; ctl.shift = 1'b1; uses_rs = 1'b0; end
          FN_SRL: begin aluc = ALUC_SRL; ctl.shift = 1'b1; uses_rs = 1'b0; end
          FN_SRA: begin aluc = ALUC_SRA; ctl.shift = 1'b1; uses_rs = 1'b0; end
          FN_JR:  begin ctl.wreg = 1'b0; is_jr = 1'b1; end
          // Unknown funct is a NOP and must not provoke a stall either.
          default: begin ctl.wreg = 1'b0; uses_rs = 1'b0; uses_rt = 1'b0; end
        endcase
      end
      OP_ADDI: begin ctl.wreg = 1'b1; ctl.aluimm = 1'b1; regrt = 1'b1; sext = 1'b1; uses_rs = 1'b1; end
      OP_ANDI: begin ctl.wreg = 1'b1; ctl.aluimm = 1'b1; regrt = 1'b1; uses_rs = 1'b1; aluc = ALUC_AND; end
      OP_ORI:  begin ctl.wreg = 1'b1; ctl.aluimm = 1'b1; regrt = 1'b1; uses_rs = 1'b1; aluc = ALUC_OR; end
      OP_XORI: begin ctl.wreg = 1'b1; ctl.aluimm = 1'b1; regrt = 1'b1; uses_rs = 1'b1; aluc = ALUC_XOR; end
      OP_LUI:  begin ctl.wreg = 1'b1; ctl.aluimm = 1'b1; regrt = 1'b1; aluc = ALUC_LUI; end
      OP_LW: begin
        ctl.wreg = 1'b1; ctl.m2reg = 1'b1; ctl.aluimm = 1'b1;
        regrt = 1'b1; sext = 1'b1; uses_rs = 1'b1;
      end
      OP_SW: begin
        ctl.wmem = 1'b1; ctl.aluimm = 1'b1;
        regrt = 1'b1; sext = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1;
      end
      OP_BEQ: begin is_beq = 1'b1; regrt = 1'b1; sext = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; aluc = ALUC_SUB; end
      OP_BNE: begin is_bne = 1'b1; regrt = 1'b1; sext = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; aluc = ALUC_SUB; end
      OP_J:   is_j = 1'b1;
      OP_JAL: begin is_j = 1'b1; ctl.wreg = 1'b1; ctl.jal = 1'b1; end
      default: ;
    endcase
  end

  assign rn = ctl.jal ? {RN_W{1'b1}} : (regrt ? rt : rd);

  pipe_fwd_unit #(.RN_W(RN_W)) u_fwd (
    .rs      (rs),
    .rt      (rt),
    .uses_rs (uses_rs),
    .uses_rt (uses_rt),
    .ewreg   (ewreg),
    .em2reg  (em2reg),
    .ern     (ern),
    .mwreg   (mwreg),
    .mm2reg  (mm2reg),
    .mrn     (mrn),
    .fwda    (fwda),
    .fwdb    (fwdb),
    .stall   (stall)
  );

  // A stalled branch is held in ID and re-evaluated once its operand arrives.
  always_comb begin
    pcsource = PC_SEQ;
    if (!stall) begin
      if ((is_beq & rsrtequ) | (is_bne & ~rsrtequ)) pcsource = PC_BR;
      else if (is_jr)                               pcsource = PC_JR;
      else if (is_j)                                pcsource = PC_JMP;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      e_ctl <= '0;
      ealuc <= '0;
      ern   <= '0;
    end else begin
      e_ctl      <= ctl;
      e_ctl.wreg <= ctl.wreg & ~stall;
      e_ctl.wmem <= ctl.wmem & ~stall;
      ealuc      <= aluc;
      ern        <= rn;
    end
  end

  assign ewreg   = e_ctl.wreg;
  assign em2reg  = e_ctl.m2reg;
  assign ewmem   = e_ctl.wmem;
  assign ealuimm = e_ctl.aluimm;
  assign eshift  = e_ctl.shift;
  assign ejal    = e_ctl.jal;

endmodule
